// File: rtl/instr_fetcher.sv
// PC generator and in-order instruction queue in front of the cache instruction port.
// Optional build macro FETCH_JAL_PREDICT_EN: follow JAL targets at fetch time instead of pc+4.
module instr_fetcher #(
    parameter int          IQ_DEPTH = 8,
    parameter int          IQ_AW    = 3,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc,
    output logic        out_mem_req,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_ready,
    input  logic [31:0] in_mem_instr,
    input  logic [31:0] in_mem_addr,
    input  logic        in_dec_ready,
    output logic        out_dec_valid,
    output logic [31:0] out_dec_instr,
    output logic [31:0] out_dec_pc,
    output logic [31:0] out_dec_pred
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [IQ_AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [IQ_AW:0]   count_q, count_d;

    logic [31:0] iq_instr_q [IQ_DEPTH];
    logic [31:0] iq_pc_q    [IQ_DEPTH];
    logic [31:0] iq_pred_q  [IQ_DEPTH];

    logic        push, pop;
    logic [31:0] pred;

`ifdef FETCH_JAL_PREDICT_EN
    logic [31:0] jal_imm;
    assign jal_imm = {{11{in_mem_instr[31]}}, in_mem_instr[31], in_mem_instr[19:12],
                      in_mem_instr[20], in_mem_instr[30:21], 1'b0};
    assign pred = (in_mem_instr[6:0] == 7'b1101111) ? pc_q + jal_imm : pc_q + 32'd4;
`else
    assign pred = pc_q + 32'd4;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (rob_clear) begin
            // Flush wins over any same-cycle response or pop.
            state_d = S_IDLE;
            pc_d    = rob_new_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            pop = (count_q != '0) && in_dec_ready;
            case (state_q)
                S_IDLE: if (count_q < (IQ_AW+1)'(IQ_DEPTH)) state_d = S_WAIT;
                S_WAIT: begin
                    // Stale responses (address mismatch) are silently discarded.
                    if (in_mem_ready && in_mem_addr == pc_q) begin
                        push    = 1'b1;
                        pc_d    = pred;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + (IQ_AW+1)'(1);
                2'b01:   count_d = count_q - (IQ_AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && push) begin
            iq_instr_q[tail_q] <= in_mem_instr;
            iq_pc_q[tail_q]    <= pc_q;
            iq_pred_q[tail_q]  <= pred;
        end
    end

    assign out_mem_req   = (state_q == S_WAIT);
    assign out_mem_addr  = pc_q;
    assign out_dec_valid = (count_q != '0);
    assign out_dec_instr = out_dec_valid ? iq_instr_q[head_q] : 32'h0;
    assign out_dec_pc    = out_dec_valid ? iq_pc_q[head_q]    : 32'h0;
    assign out_dec_pred  = out_dec_valid ? iq_pred_q[head_q]  : 32'h0;

endmodule
